hpdcache_fifo_rr_sched: RTL and testbench

HPDCACHE_FIFO_RR_SCHED -- requirements
Module: hpdcache_fifo_rr_sched

---
 rtl/hpdcache_fifo_rr_sched.sv | 195 +++++++++++++++++++
 tb/tb_hpdcache_fifo_rr_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_fifo_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : hpdcache_fifo_rr_sched
//  Brief    : Round-robin arbiter feeding a shared in-order FIFO. Each
//             requester may hold at most MAX_PEND entries in the queue at
//             any time. The head entry carries its payload and the index
//             of the requester that produced it.
//  Revision : 1.0 - initial release
// ============================================================================
module hpdcache_fifo_rr_sched #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_PEND   = 2,
    parameter type         data_t     = logic
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [N_REQ-1:0]                req_valid_i,
    output logic [N_REQ-1:0]                req_ready_o,
    input  data_t                           req_data_i [N_REQ],
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output data_t                           out_data_o,
    output logic [$clog2(N_REQ)-1:0]        out_id_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o
);

    localparam int unsigned IDW  = $clog2(N_REQ);
    localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW   = $clog2(MAX_PEND + 1);

    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(FIFO_DEPTH - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);
    localparam logic [PW-1:0]   PEND_MAX = PW'(MAX_PEND);
    localparam logic [IDW-1:0]  ID_LAST  = IDW'(N_REQ - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PTRW-1:0] rptr;
    logic [PTRW-1:0] wptr;
    logic [CNTW-1:0] count;
    logic [IDW-1:0]  rr_ptr;
    logic [PW-1:0]   pend [N_REQ];

    // Payload storage is deliberately left without reset.
    data_t           data_mem [FIFO_DEPTH];
    logic [IDW-1:0]  id_mem   [FIFO_DEPTH];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [N_REQ-1:0] eligible;
    logic             found;
    logic [IDW-1:0]   win;
    logic             full;
    logic             push;
    logic             pop;
    logic [IDW-1:0]   head_id;
    logic [N_REQ-1:0] pend_inc;
    logic [N_REQ-1:0] pend_dec;

    assign full        = (count == CNT_FULL);
    assign out_valid_o = (count != '0);
    assign pop         = out_valid_o & out_ready_i;
    assign head_id     = id_mem[rptr];
    assign out_id_o    = head_id;
    assign out_data_o  = data_mem[rptr];
    assign count_o     = count;

    // A requester may compete only while its quota of queued entries is not exhausted.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid_i[i] && (pend[i] < PEND_MAX);
        end
    end

    // Pick the first eligible requester at or above rr_ptr, wrapping around.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // Grant is blocked on a full queue (even if the head leaves this cycle) and during reset.
    always_comb begin
        req_ready_o = '0;
        push        = found && !full && rst_ni;
        if (push) begin
            req_ready_o[win] = 1'b1;
        end
    end

    // Per-requester quota events for this cycle.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pend_inc[i] = push && (win == IDW'(i));
            pend_dec[i] = pop  && (head_id == IDW'(i));
        end
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Control state: pointers, occupancy, arbitration pointer and quotas.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr   <= '0;
            wptr   <= '0;
            count  <= '0;
            rr_ptr <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                pend[i] <= '0;
            end
        end else begin
            if (push) begin
                wptr   <= (wptr == PTR_LAST) ? '0 : wptr + PTRW'(1);
                rr_ptr <= (win == ID_LAST) ? '0 : win + IDW'(1);
            end
            if (pop) begin
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + PTRW'(1);
            end
            if (push && !pop) begin
                count <= count + CNTW'(1);
            end else if (pop && !push) begin
                count <= count - CNTW'(1);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (pend_inc[i] && !pend_dec[i]) begin
                    pend[i] <= pend[i] + PW'(1);
                end else if (pend_dec[i] && !pend_inc[i]) begin
                    pend[i] <= pend[i] - PW'(1);
                end
            end
        end
    end

    // Payload write: the granted requester's data and index land at wptr.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wptr] <= req_data_i[win];
            id_mem[wptr]   <= win;
        end
    end

`ifndef SYNTHESIS
    // ------------------------------------------------------------------------
    // Consistency checks
    // ------------------------------------------------------------------------
    int unsigned pend_sum;

    // Total of all quotas, which must track queue occupancy.
    always_comb begin
        pend_sum = 0;
        for (int i = 0; i < N_REQ; i++) begin
            pend_sum = pend_sum + 32'(pend[i]);
        end
    end

    // Flag quota over/underflow, occupancy overflow, multi-hot grant and quota/occupancy drift.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (count <= CNT_FULL)
                else $error("count exceeds FIFO_DEPTH");
            assert ($onehot0(req_ready_o))
                else $error("req_ready_o not one-hot-or-zero");
            assert (pend_sum == 32'(count))
                else $error("sum of pend differs from count");
            for (int i = 0; i < N_REQ; i++) begin
                assert (pend[i] <= PEND_MAX)
                    else $error("pend[%0d] above MAX_PEND", i);
                assert (!(pend_inc[i] && !pend_dec[i] && pend[i] == PEND_MAX))
                    else $error("pend[%0d] overflow", i);
                assert (!(pend_dec[i] && !pend_inc[i] && pend[i] == '0))
                    else $error("pend[%0d] underflow", i);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_fifo_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hpdcache_fifo_rr_sched
//  Brief    : Scoreboard bench for the round-robin FIFO scheduler. A
//             queue-based reference model predicts grants; expected head
//             entries are queued and checked by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hpdcache_fifo_rr_sched;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int MP = 2;

    typedef logic [7:0] byte_t;
    typedef struct {
        byte_t d;
        int    id;
    } ent_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] req_valid = '0;
    logic [3:0] req_ready;
    byte_t      req_data [N];
    logic       out_valid;
    logic       out_ready = 1'b0;
    byte_t      out_data;
    logic [1:0] out_id;
    logic [2:0] count;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t mq[$];          // reference model queue contents
    ent_t sb[$];          // expected heads, consumed by the monitor
    int   rr       = 0;   // reference arbitration start point
    bit   mon_en   = 1'b0;
    ent_t me;

    hpdcache_fifo_rr_sched #(
        .N_REQ      (N),
        .FIFO_DEPTH (D),
        .MAX_PEND   (MP),
        .data_t     (byte_t)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_id_o    (out_id),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entries of requester i currently in the model queue.
    function automatic int pend_of(input int i);
        int c = 0;
        foreach (mq[k]) if (mq[k].id == i) c++;
        return c;
    endfunction

    // One clock of stimulus: predict the grant, check it, then update the model.
    task automatic cycle(input logic [3:0] v, input logic ordy);
        int         win;
        logic [3:0] exp_rdy;
        ent_t       e;
        @(negedge clk);
        req_valid = v;
        for (int i = 0; i < N; i++) req_data[i] = byte_t'($urandom);
        out_ready = ordy;
        #1;
        win = -1;
        if (mq.size() < D) begin
            for (int k = 0; k < N; k++) begin
                int i = (rr + k) % N;
                if (win < 0 && v[i] && pend_of(i) < MP) win = i;
            end
        end
        exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (ordy && mq.size() > 0) void'(mq.pop_front());
        if (win >= 0) begin
            e.d  = req_data[win];
            e.id = win;
            mq.push_back(e);
            sb.push_back(e);
            rr = (win + 1) % N;
        end
    endtask

    task automatic drain();
        repeat (6) cycle(4'b0000, 1'b1);
    endtask

    // Assert reset in the middle of the low clock phase and check outputs at once.
    task automatic reset_mid();
        @(negedge clk);
        req_valid = 4'b1111;
        out_ready = 1'b0;
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        mq.delete();
        sb.delete();
        rr = 0;
        req_valid = 4'b0000;
        @(negedge clk);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: compare occupancy every cycle and each popped head against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            check("count", 32'(count), 32'(sb.size()));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_empty: got a pop, expected no entry queued");
                end else begin
                    me = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(me.d));
                    check("out_id", 32'(out_id), 32'(me.id));
                end
            end
        end
    end

    int probs[6] = '{10, 50, 90, 30, 70, 100};

    initial begin
        for (int i = 0; i < N; i++) req_data[i] = '0;
        req_valid = 4'b1111;
        #12;
        check("por_out_valid", 32'(out_valid), 32'(0));
        check("por_count", 32'(count), 32'(0));
        check("por_req_ready", 32'(req_ready), 32'(0));
        req_valid = 4'b0000;
        @(negedge clk);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // All requesting, consumer always ready: rotating grants, count steady at 1.
        repeat (9) cycle(4'b1111, 1'b1);
        drain();

        // All requesting, consumer stalled: fill to four then no grants.
        repeat (6) cycle(4'b1111, 1'b0);
        drain();

        // Single requester hits its quota, then one pop frees a slot.
        repeat (3) cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b1);
        repeat (3) cycle(4'b0100, 1'b0);
        drain();

        // Same-cycle push and pop of the same requester.
        cycle(4'b0010, 1'b0);
        cycle(4'b0001, 1'b0);
        cycle(4'b0010, 1'b1);
        cycle(4'b0000, 1'b0);
        drain();

        // Randomized traffic with varying consumer throughput.
        for (int b = 0; b < 6; b++) begin
            repeat (100) cycle(4'($urandom), ($urandom_range(0, 99) < probs[b]));
        end
        drain();

        // Reset with three entries queued, then arbitration restarts from index 0.
        repeat (3) cycle(4'b1111, 1'b0);
        reset_mid();
        cycle(4'b1010, 1'b0);
        cycle(4'b1010, 1'b0);
        cycle(4'b0000, 1'b0);
        drain();

        @(negedge clk);
        #3;
        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
